// File: rtl/exec_cdb_arbiter.sv
// Per-FU result FIFOs feeding NUM_CDB round-robin common-data-bus broadcast ports.
// Optional EXEC_CDB_PERF_EN adds saturating per-FU stall and broadcast counters.
module exec_cdb_arbiter #(
  parameter int NUM_FU        = 3,
  parameter int NUM_CDB       = 1,
  parameter int FIFO_DEPTH    = 2,
  parameter int ROB_IDX_BITS  = 6,
  parameter int PHYS_REG_BITS = 6,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  output logic [NUM_FU-1:0]                    fu_ready,
  input  logic [NUM_FU*ROB_IDX_BITS-1:0]       fu_rob_idx,
  input  logic [NUM_FU*PHYS_REG_BITS-1:0]      fu_pd_s,
  input  logic [NUM_FU*5-1:0]                  fu_rd_s,
  input  logic [NUM_FU*DATA_WIDTH-1:0]         fu_rd_v,
  output logic [NUM_CDB-1:0]                   cdb_valid,
  output logic [NUM_CDB*ROB_IDX_BITS-1:0]      cdb_rob_idx,
  output logic [NUM_CDB*PHYS_REG_BITS-1:0]     cdb_pd_s,
  output logic [NUM_CDB*5-1:0]                 cdb_rd_s,
  output logic [NUM_CDB*DATA_WIDTH-1:0]        cdb_rd_v,
  output logic [NUM_CDB*$clog2(NUM_FU)-1:0]    cdb_fu_id
`ifdef EXEC_CDB_PERF_EN
  ,
  output logic [NUM_FU*32-1:0]                 perf_stall_cnt,
  output logic [NUM_FU*32-1:0]                 perf_bcast_cnt
`endif
);

  localparam int FU_ID_W = $clog2(NUM_FU);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENT_W   = ROB_IDX_BITS + PHYS_REG_BITS + 5 + DATA_WIDTH;

  logic [ENT_W-1:0]   mem_q    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_FU];
  logic [CNT_W-1:0]   count_q  [NUM_FU];
  logic [FU_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]  push, pop, nonempty;

  // Readiness comes from the registered count only, so a full FIFO never refills in the cycle it pops.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count_q[i] < CNT_W'(FIFO_DEPTH));
      nonempty[i] = (count_q[i] != '0);
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  always_comb begin
    logic [ENT_W-1:0] head;
    int idx;
    int nport;
    pop         = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid   = '0;
    cdb_rob_idx = '0;
    cdb_pd_s    = '0;
    cdb_rd_s    = '0;
    cdb_rd_v    = '0;
    cdb_fu_id   = '0;
    head        = '0;
    nport       = 0;
    for (int off = 0; off < NUM_FU; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (nonempty[idx] && (nport < NUM_CDB)) begin
        head       = mem_q[idx][rd_ptr_q[idx]];
        pop[idx]   = 1'b1;
        cdb_valid[nport] = 1'b1;
        cdb_rob_idx[nport*ROB_IDX_BITS +: ROB_IDX_BITS]   = head[ENT_W-1 -: ROB_IDX_BITS];
        cdb_pd_s[nport*PHYS_REG_BITS +: PHYS_REG_BITS]    = head[DATA_WIDTH+5+PHYS_REG_BITS-1 -: PHYS_REG_BITS];
        cdb_rd_s[nport*5 +: 5]                            = head[DATA_WIDTH+4 -: 5];
        cdb_rd_v[nport*DATA_WIDTH +: DATA_WIDTH]          = head[DATA_WIDTH-1:0];
        cdb_fu_id[nport*FU_ID_W +: FU_ID_W]               = FU_ID_W'(idx);
        rr_ptr_d   = FU_ID_W'((idx + 1) % NUM_FU);
        nport      = nport + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {fu_rob_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS],
                                  fu_pd_s[i*PHYS_REG_BITS +: PHYS_REG_BITS],
                                  fu_rd_s[i*5 +: 5],
                                  fu_rd_v[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

`ifdef EXEC_CDB_PERF_EN
  logic [31:0] stall_q [NUM_FU];
  logic [31:0] bcast_q [NUM_FU];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (rst) begin
        stall_q[i] <= '0;
        bcast_q[i] <= '0;
      end else begin
        if (fu_valid[i] && !fu_ready[i] && (stall_q[i] != '1)) stall_q[i] <= stall_q[i] + 1'b1;
        if (pop[i] && !flush && (bcast_q[i] != '1))            bcast_q[i] <= bcast_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      perf_stall_cnt[i*32 +: 32] = stall_q[i];
      perf_bcast_cnt[i*32 +: 32] = bcast_q[i];
    end
  end
`endif

  // A stalled FU must keep presenting the same result until it is accepted.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_hold_chk
    a_hold: assert property (@(posedge clk) disable iff (rst || flush)
      (fu_valid[g] && !fu_ready[g]) |=>
      (fu_valid[g] && $stable(fu_rd_v[g*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_exec_cdb_arbiter.sv
// Bench for exec_cdb_arbiter: one NUM_CDB=1 and one NUM_CDB=2 instance against a queue-based model.
module tb_exec_cdb_arbiter;
  localparam int NF    = 3;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [5:0]  rob;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [31:0] v;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [NF-1:0]    fv    [2];
  logic [NF*6-1:0]  frob  [2];
  logic [NF*6-1:0]  fpd   [2];
  logic [NF*5-1:0]  frd   [2];
  logic [NF*32-1:0] fval  [2];
  res_t             cur   [2][NF];

  logic [NF-1:0] rdy0, rdy1;
  logic [0:0]    cv0;
  logic [5:0]    crob0, cpd0;
  logic [4:0]    crd0;
  logic [31:0]   cval0;
  logic [1:0]    cfid0;
  logic [1:0]    cv1;
  logic [11:0]   crob1, cpd1;
  logic [9:0]    crd1;
  logic [63:0]   cval1;
  logic [3:0]    cfid1;

  logic [NF-1:0] dready [2];
  logic [1:0]    ov     [2];
  logic [63:0]   ow     [2][2];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      frob[n] = '0; fpd[n] = '0; frd[n] = '0; fval[n] = '0;
      for (int i = 0; i < NF; i++) begin
        frob[n][i*6 +: 6]  = cur[n][i].rob;
        fpd[n][i*6 +: 6]   = cur[n][i].pd;
        frd[n][i*5 +: 5]   = cur[n][i].rd;
        fval[n][i*32 +: 32] = cur[n][i].v;
      end
    end
  end

  always_comb begin
    dready[0] = rdy0;
    dready[1] = rdy1;
    ov[0] = {1'b0, cv0};
    ov[1] = cv1;
    ow[0][0] = {13'd0, cfid0, crob0, cpd0, crd0, cval0};
    ow[0][1] = '0;
    for (int k = 0; k < 2; k++)
      ow[1][k] = {13'd0, cfid1[k*2 +: 2], crob1[k*6 +: 6], cpd1[k*6 +: 6], crd1[k*5 +: 5], cval1[k*32 +: 32]};
  end

  exec_cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fv[0]), .fu_ready(rdy0),
    .fu_rob_idx(frob[0]), .fu_pd_s(fpd[0]), .fu_rd_s(frd[0]), .fu_rd_v(fval[0]),
    .cdb_valid(cv0), .cdb_rob_idx(crob0), .cdb_pd_s(cpd0), .cdb_rd_s(crd0),
    .cdb_rd_v(cval0), .cdb_fu_id(cfid0)
  );

  exec_cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fv[1]), .fu_ready(rdy1),
    .fu_rob_idx(frob[1]), .fu_pd_s(fpd[1]), .fu_rd_s(frd[1]), .fu_rd_v(fval[1]),
    .cdb_valid(cv1), .cdb_rob_idx(crob1), .cdb_pd_s(cpd1), .cdb_rd_s(crd1),
    .cdb_rd_v(cval1), .cdb_fu_id(cfid1)
  );

  // Reference state: buffered results per FU, scan pointer, pending source results, stall holds.
  res_t mq   [2][NF][$];
  res_t sq   [2][NF][$];
  int   mrr  [2];
  bit   hold [2][NF];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ncdb(input int n);
    return (n == 0) ? 1 : 2;
  endfunction

  task automatic drive();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NF; i++) begin
        if (hold[n][i]) begin
          fv[n][i] = 1'b1;
        end else if (sq[n][i].size() > 0) begin
          cur[n][i] = sq[n][i].pop_front();
          fv[n][i]  = 1'b1;
        end else begin
          fv[n][i] = 1'b0;
        end
      end
  endtask

  task automatic model_step(input int n);
    bit rdy [NF];
    int k, idx, last;
    for (int i = 0; i < NF; i++) rdy[i] = (mq[n][i].size() < DEPTH);
    if (rst || flush) begin
      for (int i = 0; i < NF; i++) begin
        mq[n][i].delete();
        hold[n][i] = 1'b0;
      end
      if (rst) mrr[n] = 0;
    end else begin
      k = 0;
      last = -1;
      for (int off = 0; off < NF; off++) begin
        idx = (mrr[n] + off) % NF;
        if (mq[n][idx].size() > 0 && k < ncdb(n)) begin
          void'(mq[n][idx].pop_front());
          k++;
          last = idx;
        end
      end
      if (last >= 0) mrr[n] = (last + 1) % NF;
      for (int i = 0; i < NF; i++) begin
        if (fv[n][i] && rdy[i]) mq[n][i].push_back(cur[n][i]);
        hold[n][i] = fv[n][i] && !rdy[i];
      end
    end
  endtask

  task automatic check_all();
    logic [NF-1:0] er;
    logic          ev [2];
    logic [63:0]   ew [2];
    int k, idx;
    res_t e;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NF; i++) er[i] = (mq[n][i].size() < DEPTH);
      chk($sformatf("fu_ready[%0d]", n), 64'(dready[n]), 64'(er));
      ev[0] = 0; ev[1] = 0; ew[0] = '0; ew[1] = '0;
      k = 0;
      for (int off = 0; off < NF; off++) begin
        idx = (mrr[n] + off) % NF;
        if (mq[n][idx].size() > 0 && k < ncdb(n)) begin
          e = mq[n][idx][0];
          ev[k] = 1'b1;
          ew[k] = {13'd0, 2'(idx), e.rob, e.pd, e.rd, e.v};
          k++;
        end
      end
      for (int p = 0; p < ncdb(n); p++) begin
        chk($sformatf("cdb_valid[%0d][%0d]", n, p), 64'(ov[n][p]), 64'(ev[p]));
        chk($sformatf("cdb_word[%0d][%0d]", n, p), ow[n][p], ew[p]);
      end
    end
  endtask

  task automatic tick();
    drive();
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  function automatic res_t rnd_res();
    return res_t'(49'({$urandom(), $urandom()}));
  endfunction

  task automatic push_src(input int i, input res_t r);
    sq[0][i].push_back(r);
    sq[1][i].push_back(r);
  endtask

  task automatic clear_src();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NF; i++) sq[n][i].delete();
  endtask

  initial begin
    res_t r;
    int pct;
    for (int n = 0; n < 2; n++) begin
      fv[n] = '0;
      mrr[n] = 0;
      for (int i = 0; i < NF; i++) begin
        cur[n][i] = '0;
        hold[n][i] = 1'b0;
      end
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_vld", 64'(ov[0]), 64'd0);
    chk("rst_rdy", 64'(rdy0), 64'h7);

    // Three simultaneous results drain in FU order 0, 1, 2.
    for (int i = 0; i < NF; i++) push_src(i, rnd_res());
    tick();
    chk("t2_fid0", 64'(ow[0][0][50:49]), 64'd0);
    tick();
    chk("t2_fid1", 64'(ow[0][0][50:49]), 64'd1);
    tick();
    chk("t2_fid2", 64'(ow[0][0][50:49]), 64'd2);
    tick();

    // Single add result with fixed fields.
    r = '{rob: 6'd5, pd: 6'd12, rd: 5'd3, v: 32'hDEAD_BEEF};
    push_src(0, r);
    tick();
    chk("t1_word", ow[0][0], {13'd0, 2'd0, 6'd5, 6'd12, 5'd3, 32'hDEAD_BEEF});
    chk("t1_vld", 64'(ov[0]), 64'd1);
    tick();
    chk("t1_idle", 64'(ov[0]), 64'd0);

    // Dual-port instance now has its scan pointer at FU1.
    for (int i = 0; i < NF; i++) push_src(i, rnd_res());
    tick();
    chk("t4_vld", 64'(ov[1]), 64'd3);
    chk("t4_p0fid", 64'(ow[1][0][50:49]), 64'd1);
    chk("t4_p1fid", 64'(ow[1][1][50:49]), 64'd2);
    tick();
    chk("t4_next_fid", 64'(ow[1][0][50:49]), 64'd0);
    repeat (4) tick();

    // FU1 bursts three results against a steady FU0 stream.
    for (int j = 0; j < 8; j++) push_src(0, rnd_res());
    for (int j = 0; j < 3; j++) push_src(1, rnd_res());
    repeat (14) tick();

    // Flush with buffered results and a fresh result arriving.
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NF; i++) push_src(i, rnd_res());
    tick();
    tick();
    clear_src();
    push_src(2, rnd_res());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_vld", 64'(ov[0]), 64'd0);
    chk("t5_rdy", 64'(rdy0), 64'h7);
    repeat (3) tick();

    // Reset while full, then a fresh result.
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NF; i++) push_src(i, rnd_res());
    repeat (3) tick();
    clear_src();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vld", 64'(ov[0]), 64'd0);
    chk("t6_word", ow[0][0], 64'd0);
    chk("t6_rdy", 64'(rdy0), 64'h7);
    push_src(0, rnd_res());
    push_src(2, rnd_res());
    tick();
    chk("t6_post_vld", 64'(ov[0]), 64'd1);
    chk("t6_post_fid", 64'(ow[0][0][50:49]), 64'd0);
    repeat (3) tick();

    // Randomized traffic at several load levels with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      pct = (c < 1000) ? 25 : (c < 2000) ? 60 : 95;
      for (int n = 0; n < 2; n++)
        for (int i = 0; i < NF; i++)
          if (sq[n][i].size() < 2 && $urandom_range(0, 99) < pct) sq[n][i].push_back(rnd_res());
      rst   = ($urandom_range(0, 299) == 0);
      flush = !rst && ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
